// File: rtl/display_pkg.sv
// Shared types and defaults for the paged display latch.
// The page-index width helper keeps one-page configurations at a legal 1-bit index.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        AUTO   = 2'd2
    } pager_state_e;

    localparam int DEFAULT_DATA_W     = 128;
    localparam int DEFAULT_PAGE_W     = 16;
    localparam int DEFAULT_SCROLL_DIV = 50_000_000;

    function automatic int pidx_width(input int num_pages);
        return (num_pages > 1) ? $clog2(num_pages) : 1;
    endfunction

endpackage

// File: rtl/display_pager_if.sv
// Capture/paging bus between the display source (master) and the pager (slave).
// Bit 0 of the data and page vectors is the most significant bit.
interface display_pager_if #(
    parameter int DATA_W = display_pkg::DEFAULT_DATA_W,
    parameter int PAGE_W = display_pkg::DEFAULT_PAGE_W,
    parameter int PIDX_W = display_pkg::pidx_width(DATA_W / PAGE_W)
);
    logic [0:DATA_W-1] i_data;
    logic              i_refresh_display;
    logic              i_next_page;
    logic              i_auto_scroll;
    logic              i_freeze;
    logic [0:PAGE_W-1] o_display_data;
    logic [PIDX_W-1:0] o_page_idx;
    logic              o_valid;
    logic              o_new_data;

    modport master (
        output i_data, i_refresh_display, i_next_page, i_auto_scroll, i_freeze,
        input  o_display_data, o_page_idx, o_valid, o_new_data
    );

    modport slave (
        input  i_data, i_refresh_display, i_next_page, i_auto_scroll, i_freeze,
        output o_display_data, o_page_idx, o_valid, o_new_data
    );
endinterface

// File: rtl/edge_detect_sync.sv
// Optional N-flop synchroniser followed by a rising-edge detector.
// SYNC_STAGES = 0 treats d as already synchronous and only adds the delay flop.
module edge_detect_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);
    logic synced;
    logic prev_q;

    if (SYNC_STAGES == 0) begin : g_bypass
        assign synced = d;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;

        // NOTE: flops use non-blocking assignments so every stage samples the
        // value from before the edge; blocking here would collapse the chain.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) sync_q <= '0;
            else        sync_q <= (sync_q << 1) | SYNC_STAGES'(d);
        end

        assign synced = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= 1'b0;
        else        prev_q <= synced;
    end

    assign rise = synced & ~prev_q;
endmodule

// File: rtl/display_pager.sv
// Captures a wide word on a refresh edge and shows it one page at a time,
// stepping pages from a debounced button pulse or a free-running scroll timer.
module display_pager
    import display_pkg::*;
#(
    parameter int DATA_W                = DEFAULT_DATA_W,
    parameter int PAGE_W                = DEFAULT_PAGE_W,
    parameter int SCROLL_DIV            = DEFAULT_SCROLL_DIV,
    parameter bit RESET_PAGE_ON_CAPTURE = 1'b1
) (
    input logic           clk,
    input logic           rst_n,
    display_pager_if.slave bus
);
    localparam int NUM_PAGES = DATA_W / PAGE_W;
    localparam int PIDX_W    = pidx_width(NUM_PAGES);
    localparam int TMR_W     = $clog2(SCROLL_DIV);

    if (DATA_W % PAGE_W != 0) begin : g_bad_page_w
        $error("display_pager: DATA_W must be a multiple of PAGE_W");
    end
    if (SCROLL_DIV < 2) begin : g_bad_div
        $error("display_pager: SCROLL_DIV must be at least 2");
    end

    logic [0:DATA_W-1] r_data;
    logic [0:DATA_W-1] data_buf;
    logic              r_refresh;
    logic              ref_rise, nxt, cap, tc, adv;
    logic              new_q, valid_q;
    logic [PIDX_W-1:0] idx_q, idx_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    pager_state_e      state_q, state_d;
    logic [0:PAGE_W-1] pages [NUM_PAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_refresh <= 1'b0;
        end else begin
            r_data    <= bus.i_data;
            r_refresh <= bus.i_refresh_display;
        end
    end

    // Refresh is already registered, so its detector only needs the delay flop.
    edge_detect_sync #(.SYNC_STAGES(0)) u_refresh_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (r_refresh),
        .rise (ref_rise)
    );

    edge_detect_sync #(.SYNC_STAGES(2)) u_next_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (bus.i_next_page),
        .rise (nxt)
    );

    assign cap = ref_rise & ~bus.i_freeze;
    assign tc  = (state_q == AUTO) && (tmr_q == TMR_W'(SCROLL_DIV - 1));
    assign adv = (state_q != IDLE) && (nxt || tc);

    // NOTE: every output of this block gets a default first, so no path
    // through the case/if tree can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmr_d   = '0;

        case (state_q)
            IDLE:    if (cap) state_d = bus.i_auto_scroll ? AUTO : MANUAL;
            default: state_d = bus.i_auto_scroll ? AUTO : MANUAL;
        endcase

        // Outside AUTO the timer sits at zero, so entering AUTO starts a fresh count.
        if (state_q == AUTO && !adv) tmr_d = tmr_q + 1'b1;

        if (adv) idx_d = (idx_q == PIDX_W'(NUM_PAGES - 1)) ? '0 : idx_q + 1'b1;

        if (cap && RESET_PAGE_ON_CAPTURE) begin
            idx_d = '0;
            tmr_d = '0;
        end
    end

    // NOTE: the held word is reset like any other register because the display
    // must read all-zero straight out of reset, not stale or unknown data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            tmr_q    <= '0;
            data_buf <= '0;
            new_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            new_q   <= cap;
            if (cap) begin
                data_buf <= r_data;
                valid_q  <= 1'b1;
            end
        end
    end

    for (genvar p = 0; p < NUM_PAGES; p++) begin : g_page
        assign pages[p] = data_buf[p*PAGE_W +: PAGE_W];
    end

    assign bus.o_display_data = pages[idx_q];
    assign bus.o_page_idx     = idx_q;
    assign bus.o_valid        = valid_q;
    assign bus.o_new_data     = new_q;
endmodule

// File: tb/tb_display_pager.sv
// Drives two pagers (page reset on capture on / off) with the same directed
// stimulus and compares both against an event-level model every cycle.
module tb_display_pager;
    localparam int DATA_W = 128;
    localparam int PAGE_W = 16;
    localparam int DIV    = 4;
    localparam int N      = DATA_W / PAGE_W;

    localparam logic [127:0] W1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] W2 = 128'hDEAD0001_BEEF0002_CAFE0003_F00D0004;
    localparam logic [127:0] W3 = 128'hA0A0A1A1_A2A2A3A3_A4A4A5A5_A6A6A7A7;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b1;
    logic [127:0] data   = '0;
    logic         rf     = 1'b0;
    logic         np     = 1'b0;
    logic         auto_s = 1'b0;
    logic         freeze = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    display_pager_if #(.DATA_W(DATA_W), .PAGE_W(PAGE_W)) bus0 ();
    display_pager_if #(.DATA_W(DATA_W), .PAGE_W(PAGE_W)) bus1 ();

    assign bus0.i_data            = data;
    assign bus0.i_refresh_display = rf;
    assign bus0.i_next_page       = np;
    assign bus0.i_auto_scroll     = auto_s;
    assign bus0.i_freeze          = freeze;
    assign bus1.i_data            = data;
    assign bus1.i_refresh_display = rf;
    assign bus1.i_next_page       = np;
    assign bus1.i_auto_scroll     = auto_s;
    assign bus1.i_freeze          = freeze;

    display_pager #(.DATA_W(DATA_W), .PAGE_W(PAGE_W), .SCROLL_DIV(DIV),
                    .RESET_PAGE_ON_CAPTURE(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    display_pager #(.DATA_W(DATA_W), .PAGE_W(PAGE_W), .SCROLL_DIV(DIV),
                    .RESET_PAGE_ON_CAPTURE(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Page 0 is the most significant PAGE_W bits of the word.
    function automatic logic [15:0] page_of(input bit [127:0] w, input int idx);
        return 16'(w >> (PAGE_W * (N - 1 - idx)));
    endfunction

    // Model state, index 0 = page reset on capture, index 1 = page kept.
    bit [127:0] m_word [2];
    int         m_idx  [2];
    int         m_cnt  [2];
    bit         m_started [2];
    bit         m_auto [2];
    bit         m_valid [2];
    bit         m_new  [2];
    bit         h_rf [1:2];
    bit         h_np [1:3];
    bit [127:0] h_data1;

    // A press counts two edges after its first sampled-high edge; a refresh rise
    // captures on the edge after it was sampled, using the data sampled with it.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int d = 0; d < 2; d++) begin
                    m_word[d] = '0; m_idx[d] = 0; m_cnt[d] = 0;
                    m_started[d] = 0; m_auto[d] = 0; m_valid[d] = 0; m_new[d] = 0;
                end
                h_rf[1] = 0; h_rf[2] = 0;
                h_np[1] = 0; h_np[2] = 0; h_np[3] = 0;
                h_data1 = '0;
            end else begin
                bit press, capt, tcnt, step_pg, rp;
                press = h_np[2] && !h_np[3];
                capt  = h_rf[1] && !h_rf[2] && !freeze;
                for (int d = 0; d < 2; d++) begin
                    rp      = (d == 0);
                    tcnt    = m_auto[d] && (m_cnt[d] == DIV - 1);
                    step_pg = m_started[d] && (press || tcnt);
                    if (m_auto[d] && !step_pg && !(capt && rp)) m_cnt[d]++;
                    else m_cnt[d] = 0;
                    if (capt && rp) m_idx[d] = 0;
                    else if (step_pg) m_idx[d] = (m_idx[d] + 1) % N;
                    m_new[d] = capt;
                    if (capt) begin
                        m_word[d]  = h_data1;
                        m_valid[d] = 1;
                    end
                    if (m_started[d] || capt) begin
                        if (!auto_s) m_cnt[d] = 0;
                        m_auto[d]    = auto_s;
                        m_started[d] = 1;
                    end
                end
                h_np[3] = h_np[2]; h_np[2] = h_np[1]; h_np[1] = np;
                h_rf[2] = h_rf[1]; h_rf[1] = rf;
                h_data1 = data;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("d0_data",  32'(bus0.o_display_data), 32'(page_of(m_word[0], m_idx[0])));
            check("d0_idx",   32'(bus0.o_page_idx),     32'(m_idx[0]));
            check("d0_valid", 32'(bus0.o_valid),        32'(m_valid[0]));
            check("d0_new",   32'(bus0.o_new_data),     32'(m_new[0]));
            check("d1_data",  32'(bus1.o_display_data), 32'(page_of(m_word[1], m_idx[1])));
            check("d1_idx",   32'(bus1.o_page_idx),     32'(m_idx[1]));
            check("d1_valid", 32'(bus1.o_valid),        32'(m_valid[1]));
            check("d1_new",   32'(bus1.o_new_data),     32'(m_new[1]));
        end
    end

    // Hand-computed expectations for both DUTs at a given point.
    task automatic pin(input string tag, input logic [15:0] d0, input int i0,
                       input logic [15:0] d1, input int i1, input bit v, input bit n);
        check({tag, "_d0_data"},  32'(bus0.o_display_data), 32'(d0));
        check({tag, "_d0_idx"},   32'(bus0.o_page_idx),     32'(i0));
        check({tag, "_d0_valid"}, 32'(bus0.o_valid),        32'(v));
        check({tag, "_d0_new"},   32'(bus0.o_new_data),     32'(n));
        check({tag, "_d1_data"},  32'(bus1.o_display_data), 32'(d1));
        check({tag, "_d1_idx"},   32'(bus1.o_page_idx),     32'(i1));
        check({tag, "_d1_valid"}, 32'(bus1.o_valid),        32'(v));
        check({tag, "_d1_new"},   32'(bus1.o_new_data),     32'(n));
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        np = 1'b1;
        step(5);
        np = 1'b0;
        step(5);
    endtask

    logic [15:0] w1_pages [N] = '{16'h0011, 16'h2233, 16'h4455, 16'h6677,
                                  16'h8899, 16'hAABB, 16'hCCDD, 16'hEEFF};

    initial begin
        #1 rst_n = 1'b0;
        #3;
        pin("in_reset", 16'h0000, 0, 16'h0000, 0, 0, 0);
        step(2);
        rst_n = 1'b1;
        step();
        pin("after_release", 16'h0000, 0, 16'h0000, 0, 0, 0);

        press();
        pin("idle_press", 16'h0000, 0, 16'h0000, 0, 0, 0);

        data = W1; rf = 1'b1;
        step();
        pin("cap_lat1", 16'h0000, 0, 16'h0000, 0, 0, 0);
        step();
        pin("cap_lat2", 16'h0011, 0, 16'h0011, 0, 1, 1);
        step();
        pin("cap_once", 16'h0011, 0, 16'h0011, 0, 1, 0);
        step(3);
        rf = 1'b0;

        for (int i = 1; i <= N; i++) begin
            press();
            pin($sformatf("manual_%0d", i), w1_pages[i % N], i % N, w1_pages[i % N], i % N, 1, 0);
        end

        auto_s = 1'b1;
        step(4);
        pin("auto_e3", 16'h0011, 0, 16'h0011, 0, 1, 0);
        step();
        pin("auto_e4", 16'h2233, 1, 16'h2233, 1, 1, 0);
        step(4);
        pin("auto_e8", 16'h4455, 2, 16'h4455, 2, 1, 0);
        np = 1'b1;
        step(2);
        pin("press_e10", 16'h4455, 2, 16'h4455, 2, 1, 0);
        step();
        pin("press_e11", 16'h6677, 3, 16'h6677, 3, 1, 0);
        step(2);
        np = 1'b0;
        step();
        pin("restart_e14", 16'h6677, 3, 16'h6677, 3, 1, 0);
        step();
        pin("restart_e15", 16'h8899, 4, 16'h8899, 4, 1, 0);
        auto_s = 1'b0;
        step(3);
        pin("manual_hold", 16'h8899, 4, 16'h8899, 4, 1, 0);

        auto_s = 1'b1;
        step(3);
        data = W3; rf = 1'b1;
        step();
        pin("coinc_pre", 16'h8899, 4, 16'h8899, 4, 1, 0);
        step();
        pin("coinc", 16'hA0A0, 0, 16'hA5A5, 5, 1, 1);
        auto_s = 1'b0; rf = 1'b0;
        step(2);

        freeze = 1'b1; data = W2; rf = 1'b1;
        step(4);
        pin("frozen", 16'hA0A0, 0, 16'hA5A5, 5, 1, 0);
        freeze = 1'b0;
        step(4);
        pin("unfreeze_high", 16'hA0A0, 0, 16'hA5A5, 5, 1, 0);
        rf = 1'b0;
        step(2);
        rf = 1'b1;
        step(2);
        pin("recapture", 16'hDEAD, 0, 16'h0003, 5, 1, 1);
        rf = 1'b0;
        step();

        repeat (5) press();
        pin("pre_reset", 16'h0003, 5, 16'hBEEF, 2, 1, 0);
        auto_s = 1'b1;
        step(2);
        data = W1; rf = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        pin("async_reset", 16'h0000, 0, 16'h0000, 0, 0, 0);
        rf = 1'b0;
        step(2);
        rst_n = 1'b1;
        step();
        pin("post_reset", 16'h0000, 0, 16'h0000, 0, 0, 0);
        press();
        pin("post_reset_press", 16'h0000, 0, 16'h0000, 0, 0, 0);
        step(4);
        pin("no_lost_capture", 16'h0000, 0, 16'h0000, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/display_pager.md
Name: display_pager

Overview:
- Parametrised successor to the single-word display latch.
- Captures a wide data word (default 128-bit AES state/key) on a rising edge of a refresh request and holds it.
- Presents the held word one PAGE_W-bit page at a time to the 4-digit hex display driver.
- Pages advance manually (button pulse) or automatically (scroll timer). A freeze input blocks new captures.

Parameters:
- DATA_W, 128: width of captured word; must be an integer multiple of PAGE_W (elaboration-time assertion).
- PAGE_W, 16: width of one displayed page.
- SCROLL_DIV, 50_000_000: clock cycles per page in auto mode; must be >= 2.
- RESET_PAGE_ON_CAPTURE, 1: 1 = page index returns to 0 on every capture; 0 = index is kept.
- Derived: NUM_PAGES = DATA_W/PAGE_W; PIDX_W = max(1, $clog2(NUM_PAGES)).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_data  in  [0:DATA_W-1]  word to capture; bit 0 is the MSB
- i_refresh_display  in  1  level request; the rising edge triggers a capture
- i_next_page  in  1  manual page-advance request (asynchronous button level); synchronised internally
- i_auto_scroll  in  1  1 = timer-driven paging, 0 = manual paging
- i_freeze  in  1  1 = ignore capture requests
- o_display_data  out  [0:PAGE_W-1]  current page of the held word
- o_page_idx  out  PIDX_W  index of the page currently shown
- o_valid  out  1  high once at least one capture has occurred
- o_new_data  out  1  one-cycle pulse in the cycle the buffer updates

Behaviour:
- Reset:
  - Asynchronous on rst_n low; all registers clear immediately.
  - o_display_data=0, o_page_idx=0, o_valid=0, o_new_data=0, timer=0, state=IDLE.
  - Release is sampled on the next clk edge.
- Input stage: i_data and i_refresh_display are registered every cycle (r_data, r_refresh); r_refresh is delayed once more (r_refresh_d).
- Capture:
  - cap = r_refresh & ~r_refresh_d & ~i_freeze.
  - On cap, buf <= r_data at the next edge.
  - Latency: i_refresh_display rises before edge k; edge k registers it; buf updates and o_new_data is high after edge k+1.
  - A held-high refresh captures exactly once.
- Freeze: while i_freeze=1, any refresh edge seen is dropped, not queued. Paging continues.
- Output: o_display_data = buf[o_page_idx*PAGE_W +: PAGE_W]. This is a combinational mux from registered buf/idx, so it is glitch-free relative to clk.
- Page 0 is bits [0:PAGE_W-1].
- Manual advance:
  - i_next_page passes through a 2-flop synchroniser, then a rising-edge detector, giving nxt (one pulse per press).
  - Page index increments on nxt and wraps NUM_PAGES-1 -> 0.
- Auto advance:
  - Timer counts 0..SCROLL_DIV-1 while state=AUTO.
  - At terminal count the page index increments (with wrap) and the timer returns to 0.
  - nxt in AUTO also advances the page and clears the timer.
- State machine:
  - IDLE -> MANUAL or AUTO on first cap, chosen by i_auto_scroll.
  - MANUAL <-> AUTO follows i_auto_scroll each cycle. Entering AUTO clears the timer.
  - No return to IDLE except by reset.
  - In IDLE, paging requests are ignored and o_page_idx stays 0.
- o_valid: set on the first cap; stays high until reset.
- Simultaneous events:
  - cap together with advance (nxt or terminal count), RESET_PAGE_ON_CAPTURE=1: index becomes 0 and the timer clears.
  - Same case with RESET_PAGE_ON_CAPTURE=0: the advance is applied and the new data is shown at the advanced index.
- NUM_PAGES=1: index is constant 0 and advances are no-ops.
- Reset mid-scroll or mid-capture: the in-flight capture is lost and the state is as at reset.

Decomposition:
- Package display_pkg holds:
  - the state enum (IDLE, MANUAL, AUTO);
  - default constants DATA_W, PAGE_W, SCROLL_DIV;
  - a function computing PIDX_W.
- One sub-module, edge_detect_sync (params SYNC_STAGES default 2, 0 = bypass), outputs a rising-edge pulse.
  - Instantiated for i_next_page with SYNC_STAGES=2.
  - Instantiated for the refresh path with SYNC_STAGES=0, using the existing registers.

Test Plan:
- Reset, then a refresh edge with i_data=128'h00112233_44556677_8899AABB_CCDDEEFF -> after 2 edges: o_valid=1, o_new_data pulses once, o_display_data=16'h0011, o_page_idx=0.
- Manual mode, 8 presses of i_next_page (each held 5 cycles) -> pages 2233, 4455, 6677, 8899, AABB, CCDD, EEFF, then wrap to 0011. Exactly one advance per press.
- Auto mode with SCROLL_DIV=4 -> the page advances every 4 cycles. A press mid-count advances immediately and restarts the 4-cycle count.
- i_freeze=1 with a refresh edge and new i_data -> buf unchanged, no o_new_data. Freeze deasserted with refresh still high -> no capture until the next rising edge.
- Capture coincident with the auto terminal count, RESET_PAGE_ON_CAPTURE=1 -> o_page_idx=0 showing the new page 0. Repeat with the parameter=0 -> index advances and the new data is shown at that index.
- rst_n asserted asynchronously mid-scroll at page 5 -> outputs zero before the next clk edge. After release: IDLE, o_valid=0, and presses are ignored until a capture.
